// File: rtl/scan_pkg.sv
// Shared types and constants for the multiplexed 2-digit scan scheduler.
// Optional build macro used by the top: LEADING_ZERO_BLANK_EN.
package scan_pkg;

   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      DIG0   = 2'd1,
      BLANK1 = 2'd2,
      DIG1   = 2'd3
   } scan_state_e;

   localparam logic [1:0] COM_OFF = 2'b00;
   localparam logic [1:0] COM_D0  = 2'b01;
   localparam logic [1:0] COM_D1  = 2'b10;

   // Never returns less than 1, so a counter always has at least one bit.
   function automatic int scan_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot counter 0..SLOT-1 with wrap, plus end-of-blank and end-of-slot strobes.
module scan_slot_timer #(
   parameter int SLOT         = 10,
   parameter int BLANK_CYCLES = 2,
   parameter int CNT_W        = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             slotEnd_o,
   output logic             blankEnd_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      slotEnd_o  = (cnt_q == CNT_W'(SLOT - 1));
      blankEnd_o = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
      cnt_d      = slotEnd_o ? '0 : cnt_q + 1'b1;
      cnt_o      = cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/scan_display_scheduler.sv
// Two-digit scan scheduler: blanked dead-time between digits, frame-aligned data commit.
// Build macro LEADING_ZERO_BLANK_EN suppresses the left digit while its code is zero.
module scan_display_scheduler
   import scan_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 50000000,
   parameter int SCAN_HZ      = 1000,
   parameter int BLANK_CYCLES = 500,
   parameter int DATA_W       = 4
) (
   input  logic              sysClk,
   input  logic              sysRst,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic              updReq,
   output logic              updAck,
   output logic [1:0]        COM,
   output logic [DATA_W-1:0] boundedData,
   output logic              blank,
   output logic              frameStart
);

   localparam int SLOT  = CLK_FREQ_HZ / SCAN_HZ;
   localparam int CNT_W = scan_clog2(SLOT);

   scan_state_e       state_q, state_d;
   logic [DATA_W-1:0] shadow1_q, shadow1_d;
   logic [DATA_W-1:0] shadow2_q, shadow2_d;
   logic [DATA_W-1:0] bd_q, bd_d;
   logic [CNT_W-1:0]  cnt;
   logic              slot_end, blank_end;
   logic              frame_bnd, load;
   logic              dig0_show_q, dig0_show_d;

   scan_slot_timer #(
      .SLOT         (SLOT),
      .BLANK_CYCLES (BLANK_CYCLES),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk_i      (sysClk),
      .rst_i      (sysRst),
      .cnt_o      (cnt),
      .slotEnd_o  (slot_end),
      .blankEnd_o (blank_end)
   );

`ifdef LEADING_ZERO_BLANK_EN
   assign dig0_show_q = |shadow1_q;
   assign dig0_show_d = |shadow1_d;
`else
   assign dig0_show_q = 1'b1;
   assign dig0_show_d = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BLANK0:  if (blank_end) state_d = DIG0;
         DIG0:    if (slot_end)  state_d = BLANK1;
         BLANK1:  if (blank_end) state_d = DIG1;
         DIG1:    if (slot_end)  state_d = BLANK0;
         default: state_d = BLANK0;
      endcase

      // The ack must land in the boundary cycle itself, so it is qualified by the
      // live request; reset gating keeps both pulses quiet while reset is held.
      frame_bnd  = (state_q == BLANK0) && (cnt == '0);
      load       = frame_bnd && updReq && !sysRst;
      updAck     = load;
      frameStart = frame_bnd && !sysRst;

      shadow1_d = load ? data1 : shadow1_q;
      shadow2_d = load ? data2 : shadow2_q;

      bd_d = bd_q;
      if (state_d == DIG0 && dig0_show_d) bd_d = shadow1_d;
      else if (state_d == DIG1)           bd_d = shadow2_d;

      COM   = COM_OFF;
      blank = 1'b1;
      if (state_q == DIG0 && dig0_show_q) begin
         COM   = COM_D0;
         blank = 1'b0;
      end else if (state_q == DIG1) begin
         COM   = COM_D1;
         blank = 1'b0;
      end
      boundedData = bd_q;
   end

   always_ff @(posedge sysClk) begin
      if (sysRst) begin
         state_q   <= BLANK0;
         shadow1_q <= '0;
         shadow2_q <= '0;
         bd_q      <= '0;
      end else begin
         state_q   <= state_d;
         shadow1_q <= shadow1_d;
         shadow2_q <= shadow2_d;
         bd_q      <= bd_d;
      end
   end

endmodule
